// File: rtl/type_pkg.sv
// Shared DDR encodings used by the scheduler and the bank monitors.
// Every command is driven as {CS,RAS,CAS,WE}. Bank readiness comes from the per-bank monitors.
package type_pkg;

  typedef enum logic [3:0] {
    CMD_MRS        = 4'b0000,
    CMD_REFRESH    = 4'b0001,
    CMD_PRECHARGE  = 4'b0010,
    CMD_ACTIVE     = 4'b0011,
    CMD_WRITE      = 4'b0100,
    CMD_READ       = 4'b0101,
    CMD_BURST_TERM = 4'b0110,
    CMD_NOP        = 4'b0111,
    CMD_DESELECT   = 4'b1111
  } commands_t;

  typedef enum logic [1:0] {
    BANK_NOT_READY   = 2'd0,
    BANK_READ_READY  = 2'd1,
    BANK_WRITE_READY = 2'd2,
    BANK_FULL_READY  = 2'd3
  } bank_status_t;

  typedef enum logic [1:0] {
    BURST_2 = 2'd1,
    BURST_4 = 2'd2,
    BURST_8 = 2'd3
  } burst_size_t;

  typedef enum logic [1:0] {
    INIT      = 2'd0,
    INIT_WAIT = 2'd1,
    RUN       = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: grants the first set request at or after ptr, wrapping.
// Returns both a one-hot grant and the winner index.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// DDR command scheduler: MRS init, round-robin request latch, and an open-row table per bank.
// Commands are gated on monitor status and driven combinationally in the cycle they are decided.
module ddr_cmd_scheduler
  import type_pkg::*;
#(
  parameter int               NREQ      = 2,
  parameter int               ROW_W     = 13,
  parameter int               COL_W     = 10,
  parameter logic [ROW_W-1:0] MODE_WORD = 'h0030
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_write,
  input  logic [NREQ-1:0][1:0]       req_bank,
  input  logic [NREQ-1:0][ROW_W-1:0] req_row,
  input  logic [NREQ-1:0][COL_W-1:0] req_col,
  output logic [NREQ-1:0]            req_grant,
  input  bank_status_t [3:0]         bank_status,
  output logic                       CS,
  output logic                       RAS,
  output logic                       CAS,
  output logic                       WE,
  output logic [1:0]                 B,
  output logic [ROW_W-1:0]           A
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_t state_q, state_d;
  logic                   lat_vld_q;
  logic                   lat_write_q;
  logic [1:0]             lat_bank_q;
  logic [ROW_W-1:0]       lat_row_q;
  logic [COL_W-1:0]       lat_col_q;
  logic [IW-1:0]          lat_idx_q;
  logic [NREQ-1:0]        lat_gnt_q;
  logic [IW-1:0]          rr_ptr_q;
  logic [3:0]             open_vld_q;
  logic [3:0][ROW_W-1:0]  open_row_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  commands_t        cmd;
  logic [1:0]       b_d;
  logic [ROW_W-1:0] a_d;
  bank_status_t     st;
  logic             do_latch, do_act, do_pre, do_rw;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    cmd      = CMD_NOP;
    b_d      = '0;
    a_d      = '0;
    state_d  = state_q;
    do_latch = 1'b0;
    do_act   = 1'b0;
    do_pre   = 1'b0;
    do_rw    = 1'b0;
    st       = bank_status[lat_bank_q];
    case (state_q)
      INIT: begin
        cmd     = CMD_MRS;
        a_d     = MODE_WORD;
        state_d = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (bank_status[0] == BANK_FULL_READY) state_d = RUN;
      end
      RUN: begin
        if (!lat_vld_q) begin
          do_latch = arb_any;
        end else if (!open_vld_q[lat_bank_q]) begin
          if (st == BANK_FULL_READY) begin
            cmd    = CMD_ACTIVE;
            b_d    = lat_bank_q;
            a_d    = lat_row_q;
            do_act = 1'b1;
          end
        end else if (open_row_q[lat_bank_q] != lat_row_q) begin
          if (st == BANK_FULL_READY) begin
            cmd    = CMD_PRECHARGE;
            b_d    = lat_bank_q;
            do_pre = 1'b1;
          end
        end else if (!lat_write_q) begin
          if (st == BANK_FULL_READY || st == BANK_READ_READY) begin
            cmd   = CMD_READ;
            b_d   = lat_bank_q;
            a_d   = ROW_W'(lat_col_q);
            do_rw = 1'b1;
          end
        end else if (st == BANK_FULL_READY || st == BANK_WRITE_READY) begin
          cmd   = CMD_WRITE;
          b_d   = lat_bank_q;
          a_d   = ROW_W'(lat_col_q);
          do_rw = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Reset forces the bus idle immediately, without waiting for a clock edge
  assign {CS, RAS, CAS, WE} = rst ? CMD_NOP : cmd;
  assign B         = rst ? 2'b00 : b_d;
  assign A         = rst ? '0 : a_d;
  assign req_grant = (do_rw && !rst) ? lat_gnt_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      lat_vld_q  <= 1'b0;
      rr_ptr_q   <= '0;
      open_vld_q <= '0;
    end else begin
      state_q <= state_d;
      if (do_latch)   lat_vld_q <= 1'b1;
      else if (do_rw) lat_vld_q <= 1'b0;
      if (do_rw) rr_ptr_q <= (lat_idx_q == IW'(NREQ - 1)) ? '0 : lat_idx_q + IW'(1);
      if (do_act) open_vld_q[lat_bank_q] <= 1'b1;
      if (do_pre) open_vld_q[lat_bank_q] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_latch) begin
      lat_write_q <= req_write[arb_idx];
      lat_bank_q  <= req_bank[arb_idx];
      lat_row_q   <= req_row[arb_idx];
      lat_col_q   <= req_col[arb_idx];
      lat_idx_q   <= arb_idx;
      lat_gnt_q   <= arb_gnt;
    end
    if (do_act) open_row_q[lat_bank_q] <= lat_row_q;
  end

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Bench for ddr_cmd_scheduler: a bank-monitor model plus a scoreboard of expected bus commands.
// Each entry is {cmd, B, A, req_grant}.
module tb_ddr_cmd_scheduler;
  import type_pkg::*;

  localparam logic [12:0] MODE_WORD = 13'h0030;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       req_valid, req_write, req_grant;
  logic [1:0][1:0]  req_bank;
  logic [1:0][12:0] req_row;
  logic [1:0][9:0]  req_col;
  bank_status_t [3:0] bank_status;
  logic             CS, RAS, CAS, WE;
  logic [1:0]       B;
  logic [12:0]      A;

  bank_status_t base [4];
  int           busy [4];
  logic         pend [4];
  logic [31:0]  exp_q [$];
  int           n_chk = 0;
  int           n_pass = 0;
  int           lat;

  always #5 clk = ~clk;

  ddr_cmd_scheduler #(.NREQ(2), .ROW_W(13), .COL_W(10), .MODE_WORD(MODE_WORD)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col), .req_grant(req_grant),
    .bank_status(bank_status), .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE), .B(B), .A(A)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ent(commands_t c, logic [1:0] b, logic [12:0] a, logic [1:0] g);
    return {11'd0, c, b, a, g};
  endfunction

  function automatic logic [31:0] cmd_now();
    return {28'd0, CS, RAS, CAS, WE};
  endfunction

  // Scoreboard: every non-NOP bus command must match the next queued expectation
  always @(negedge clk) begin
    logic [3:0]  c;
    logic [31:0] obs;
    c   = {CS, RAS, CAS, WE};
    obs = {11'd0, CS, RAS, CAS, WE, B, A, req_grant};
    if (!rst) begin
      if (c != CMD_NOP) begin
        if (exp_q.size() != 0) chk("sb_cmd", obs, exp_q.pop_front());
        else chk("sb_unexpected", obs, 32'd0);
      end else if (req_grant != 2'b00) begin
        chk("grant_on_nop", {30'd0, req_grant}, 32'd0);
      end
    end
    for (int b = 0; b < 4; b++)
      pend[b] = !rst && (c == CMD_ACTIVE || c == CMD_PRECHARGE) && (B == 2'(b));
  end

  // Bank monitor model: not ready for two cycles after ACTIVE/PRECHARGE, else base status
  always @(posedge clk) begin
    #1;
    for (int b = 0; b < 4; b++) begin
      if (rst) busy[b] = 0;
      else if (pend[b]) busy[b] = 2;
      else if (busy[b] > 0) busy[b] = busy[b] - 1;
      bank_status[b] = (busy[b] != 0) ? BANK_NOT_READY : base[b];
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int i, input logic w, input logic [1:0] b,
                       input logic [12:0] r, input logic [9:0] c);
    req_write[i] = w;
    req_bank[i]  = b;
    req_row[i]   = r;
    req_col[i]   = c;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_grant(input int i, input int budget, output int l);
    l = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (req_grant[i]) begin
        l = n;
        req_valid[i] = 1'b0;
        break;
      end
    end
    if (l == 0) chk("grant_timeout", {30'd0, req_grant}, 32'd1 << i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0; req_write = '0; req_bank = '0; req_row = '0; req_col = '0;
    for (int b = 0; b < 4; b++) begin
      base[b] = BANK_FULL_READY;
      busy[b] = 0;
      pend[b] = 1'b0;
    end
    base[0] = BANK_NOT_READY;
    #1 rst = 1'b1;
    #1;
    chk("rst_cmd", cmd_now(), 32'(CMD_NOP));
    chk("rst_b", 32'(B), 32'd0);
    chk("rst_a", 32'(A), 32'd0);
    chk("rst_grant", 32'(req_grant), 32'd0);
    repeat (2) tick();

    exp_q.push_back(ent(CMD_MRS, 2'd0, MODE_WORD, 2'b00));
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("init_wait_nop", cmd_now(), 32'(CMD_NOP));
    end
    tick();
    base[0] = BANK_FULL_READY;
    repeat (4) begin
      @(negedge clk);
      chk("idle_nop", cmd_now(), 32'(CMD_NOP));
    end

    // Idle bank: ACTIVE, monitor window, then READ
    tick();
    exp_q.push_back(ent(CMD_ACTIVE, 2'd1, 13'd5, 2'b00));
    exp_q.push_back(ent(CMD_READ,   2'd1, 13'd3, 2'b01));
    drive(0, 1'b0, 2'd1, 13'd5, 10'd3);
    wait_grant(0, 20, lat);
    chk("lat_idle_bank", 32'(lat), 32'd5);

    // Row hits with partial readiness
    tick();
    base[1] = BANK_READ_READY;
    exp_q.push_back(ent(CMD_READ, 2'd1, 13'd7, 2'b01));
    drive(0, 1'b0, 2'd1, 13'd5, 10'd7);
    wait_grant(0, 10, lat);
    chk("lat_hit_read", 32'(lat), 32'd2);

    tick();
    base[1] = BANK_WRITE_READY;
    exp_q.push_back(ent(CMD_WRITE, 2'd1, 13'd8, 2'b01));
    drive(0, 1'b1, 2'd1, 13'd5, 10'd8);
    wait_grant(0, 10, lat);
    chk("lat_hit_write", 32'(lat), 32'd2);

    tick();
    base[1] = BANK_NOT_READY;
    exp_q.push_back(ent(CMD_READ, 2'd1, 13'd9, 2'b01));
    drive(0, 1'b0, 2'd1, 13'd5, 10'd9);
    repeat (4) @(negedge clk);
    chk("stall_no_grant", 32'(req_grant), 32'd0);
    base[1] = BANK_FULL_READY;
    wait_grant(0, 10, lat);
    chk("lat_after_stall", 32'(lat), 32'd1);

    // Row conflict from requester 1
    tick();
    exp_q.push_back(ent(CMD_PRECHARGE, 2'd1, 13'd0, 2'b00));
    exp_q.push_back(ent(CMD_ACTIVE,    2'd1, 13'd9, 2'b00));
    exp_q.push_back(ent(CMD_WRITE,     2'd1, 13'd2, 2'b10));
    drive(1, 1'b1, 2'd1, 13'd9, 10'd2);
    wait_grant(1, 30, lat);
    chk("lat_conflict", 32'(lat), 32'd8);

    tick();
    exp_q.push_back(ent(CMD_READ, 2'd1, 13'd4, 2'b10));
    drive(1, 1'b0, 2'd1, 13'd9, 10'd4);
    wait_grant(1, 10, lat);
    chk("lat_row9_hit", 32'(lat), 32'd2);

    // Both requesters held: grants alternate starting at 0
    tick();
    for (int g = 0; g < 2; g++) begin
      exp_q.push_back(ent(CMD_READ, 2'd1, 13'd1, 2'b01));
      exp_q.push_back(ent(CMD_READ, 2'd1, 13'd6, 2'b10));
    end
    drive(0, 1'b0, 2'd1, 13'd9, 10'd1);
    drive(1, 1'b0, 2'd1, 13'd9, 10'd6);
    for (int g = 0; g < 4; g++) begin
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        if (req_grant != 2'b00) break;
      end
      chk("rr_order", 32'(req_grant), (g % 2 == 0) ? 32'd1 : 32'd2);
      if (g == 3) req_valid = 2'b00;
    end

    // Reset while ACTIVE is on the bus
    tick();
    exp_q.push_back(ent(CMD_ACTIVE, 2'd2, 13'd3, 2'b00));
    drive(0, 1'b0, 2'd2, 13'd3, 10'd1);
    @(negedge clk);
    @(negedge clk);
    chk("act_pending", cmd_now(), 32'(CMD_ACTIVE));
    #2 rst = 1'b1;
    req_valid = 2'b00;
    #1;
    chk("rst_async_cmd", cmd_now(), 32'(CMD_NOP));
    chk("rst_async_grant", 32'(req_grant), 32'd0);
    chk("rst_async_b", 32'(B), 32'd0);
    repeat (2) tick();
    exp_q.push_back(ent(CMD_MRS, 2'd0, MODE_WORD, 2'b00));
    rst = 1'b0;
    repeat (3) tick();

    // Row 9 was open before reset; table must have been cleared
    exp_q.push_back(ent(CMD_ACTIVE, 2'd1, 13'd9, 2'b00));
    exp_q.push_back(ent(CMD_READ,   2'd1, 13'd5, 2'b01));
    drive(0, 1'b0, 2'd1, 13'd9, 10'd5);
    wait_grant(0, 20, lat);
    chk("lat_after_reset", 32'(lat), 32'd5);

    repeat (5) @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
